output_argmax: RTL and testbench

- Classification stage directly downstream of the output-layer neurons.
- Consumes the NUM_CLASSES signed Q1.15 neuron results as a serial valid/ready stream, one result per beat.
- Tracks the running maximum and emits the winning class index, plus the winning score, through a valid/ready result port.
- Feeds the top-level result register and display logic.

---
 rtl/nn_pkg.sv | 14 +
 rtl/argmax_cmp_update.sv | 54 +++++
 rtl/output_argmax.sv | 135 +++++++++++++
 tb/tb_output_argmax.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network classification path.
package nn_pkg;

    typedef logic signed [15:0] q15_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } argmax_state_e;

    localparam int NN_NUM_CLASSES = 10;

endpackage

// File: rtl/argmax_cmp_update.sv
// Combinational compare/update of the running (best, idx[, second, idx2]) tuple.
// Runner-up tracking is present only when ARGMAX_RUNNER_UP_EN is defined.
module argmax_cmp_update #(
    parameter int DATA_W  = 16,
    parameter int CLASS_W = 4
) (
    input  logic                      first,
    input  logic signed [DATA_W-1:0]  cand,
    input  logic        [CLASS_W-1:0] cand_idx,
    input  logic signed [DATA_W-1:0]  best,
    input  logic        [CLASS_W-1:0] best_idx,
`ifdef ARGMAX_RUNNER_UP_EN
    input  logic                      has_second,
    input  logic signed [DATA_W-1:0]  second,
    input  logic        [CLASS_W-1:0] second_idx,
    output logic signed [DATA_W-1:0]  second_nxt,
    output logic        [CLASS_W-1:0] second_idx_nxt,
`endif
    output logic signed [DATA_W-1:0]  best_nxt,
    output logic        [CLASS_W-1:0] best_idx_nxt
);

    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
`ifdef ARGMAX_RUNNER_UP_EN
        second_nxt     = second;
        second_idx_nxt = second_idx;
`endif
        if (first) begin
            best_nxt     = cand;
            best_idx_nxt = '0;
`ifdef ARGMAX_RUNNER_UP_EN
            // Mirror the first beat so a one-beat frame reports a zero margin.
            second_nxt     = cand;
            second_idx_nxt = '0;
`endif
        end else if (cand > best) begin
            best_nxt     = cand;
            best_idx_nxt = cand_idx;
`ifdef ARGMAX_RUNNER_UP_EN
            second_nxt     = best;
            second_idx_nxt = best_idx;
`endif
        end
`ifdef ARGMAX_RUNNER_UP_EN
        else if (!has_second || (cand > second)) begin
            second_nxt     = cand;
            second_idx_nxt = cand_idx;
        end
`endif
    end

endmodule

// File: rtl/output_argmax.sv
// Streaming argmax over one frame of output-layer results with a held valid/ready result.
// Optional runner-up class and margin outputs: define ARGMAX_RUNNER_UP_EN.
module output_argmax
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_NUM_CLASSES,
    parameter int CLASS_W     = 4,
    parameter int DATA_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [CLASS_W-1:0] out_class,
    output logic        [DATA_W-1:0]  out_score,
`ifdef ARGMAX_RUNNER_UP_EN
    output logic        [CLASS_W-1:0] out_class2,
    output logic        [DATA_W:0]    out_margin,
`endif
    output logic                      out_err
);

    localparam int CNT_W = CLASS_W + 1;
    localparam logic [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    argmax_state_e state, state_next;

    logic                      accept;
    logic                      first;
    logic                      at_len;
    logic                      frame_end;
    logic                      frame_err;
    logic        [CNT_W-1:0]   count;
    logic        [CNT_W-1:0]   beat_cnt;
    logic        [CNT_W-1:0]   count_next;
    logic signed [DATA_W-1:0]  best, best_nxt;
    logic        [CLASS_W-1:0] idx, idx_nxt;
`ifdef ARGMAX_RUNNER_UP_EN
    logic signed [DATA_W-1:0]  second, second_nxt;
    logic        [CLASS_W-1:0] idx2, idx2_nxt;
    logic                      has_second;
`endif

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (state == IDLE);

    // IDLE starts a fresh frame regardless of the stale count left by the last one.
    assign beat_cnt   = first ? '0 : count;
    assign count_next = beat_cnt + 1'b1;
    assign at_len     = (count_next == CNT_W'(NUM_CLASSES));
    assign frame_end  = accept && (in_last || at_len);
    assign frame_err  = (in_last != at_len);
`ifdef ARGMAX_RUNNER_UP_EN
    assign has_second = (beat_cnt >= CNT_W'(2));
`endif

    argmax_cmp_update #(
        .DATA_W  (DATA_W),
        .CLASS_W (CLASS_W)
    ) u_cmp (
        .first          (first),
        .cand           (in_data),
        .cand_idx       (beat_cnt[CLASS_W-1:0]),
        .best           (best),
        .best_idx       (idx),
`ifdef ARGMAX_RUNNER_UP_EN
        .has_second     (has_second),
        .second         (second),
        .second_idx     (idx2),
        .second_nxt     (second_nxt),
        .second_idx_nxt (idx2_nxt),
`endif
        .best_nxt       (best_nxt),
        .best_idx_nxt   (idx_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = frame_end ? HOLD : ACCUM;
            ACCUM:   if (frame_end) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            best      <= SCORE_MIN;
            idx       <= '0;
            out_class <= '0;
            out_score <= '0;
            out_err   <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
            second     <= SCORE_MIN;
            idx2       <= '0;
            out_class2 <= '0;
            out_margin <= '0;
`endif
        end else if (accept) begin
            count <= count_next;
            best  <= best_nxt;
            idx   <= idx_nxt;
`ifdef ARGMAX_RUNNER_UP_EN
            second <= second_nxt;
            idx2   <= idx2_nxt;
`endif
            if (frame_end) begin
                out_class <= idx_nxt;
                out_score <= best_nxt;
                out_err   <= frame_err;
`ifdef ARGMAX_RUNNER_UP_EN
                out_class2 <= idx2_nxt;
                out_margin <= {best_nxt[DATA_W-1], best_nxt} - {second_nxt[DATA_W-1], second_nxt};
`endif
            end
        end
    end

endmodule

// File: tb/tb_output_argmax.sv
// Scoreboard bench for output_argmax; checks runner-up outputs when ARGMAX_RUNNER_UP_EN is defined.
module tb_output_argmax;

    localparam int NUM = 10;

    typedef struct {
        logic [3:0]  cls;
        logic [15:0] score;
        logic        err;
        logic [3:0]  cls2;
        logic [16:0] margin;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_class;
    logic [15:0]        out_score;
    logic               out_err;
`ifdef ARGMAX_RUNNER_UP_EN
    logic [3:0]         out_class2;
    logic [16:0]        out_margin;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t last_e;
    exp_t mon_e;
    int   frm[$];

    output_argmax #(
        .NUM_CLASSES (NUM),
        .CLASS_W     (4),
        .DATA_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_score  (out_score),
`ifdef ARGMAX_RUNNER_UP_EN
        .out_class2 (out_class2),
        .out_margin (out_margin),
`endif
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives frm[] one beat per accepted cycle; expected result comes from a plain argmax model.
    task automatic send_frame(input bit last_on_end);
        int                 n = frm.size();
        int                 bi;
        int                 si;
        int                 waits;
        bit                 acc;
        bit                 ends;
        logic signed [15:0] bv;
        logic signed [15:0] sv;
        logic signed [15:0] v;
        exp_t               e;
        bv = 16'(frm[0]);
        bi = 0;
        for (int i = 1; i < n; i++) begin
            v = 16'(frm[i]);
            if (v > bv) begin
                bv = v;
                bi = i;
            end
        end
        si = -1;
        sv = '0;
        for (int j = 0; j < n; j++) begin
            v = 16'(frm[j]);
            if (j != bi && (si < 0 || v > sv)) begin
                sv = v;
                si = j;
            end
        end
        e.cls   = 4'(bi);
        e.score = bv;
        e.err   = (n != NUM) || !last_on_end;
        if (n == 1) begin
            e.cls2   = '0;
            e.margin = '0;
        end else begin
            e.cls2   = 4'(si);
            e.margin = 17'(int'(bv) - int'(sv));
        end
        ends = last_on_end || (n == NUM);
        if (ends) begin
            exp_q.push_back(e);
            last_e = e;
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(frm[i]);
            in_last  = last_on_end && (i == n - 1);
            waits    = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                waits++;
            end while (!acc && waits < 50);
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ends) begin
            @(negedge clk);
            check("lat_valid", 32'(out_valid), 32'd1);
            check("lat_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_class", 32'(out_class), 32'(mon_e.cls));
                check("out_score", 32'(out_score), 32'(mon_e.score));
                check("out_err", 32'(out_err), 32'(mon_e.err));
`ifdef ARGMAX_RUNNER_UP_EN
                check("out_class2", 32'(out_class2), 32'(mon_e.cls2));
                check("out_margin", 32'(out_margin), 32'(mon_e.margin));
`endif
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_class"}, 32'(out_class), 32'd0);
        check({tag, "_out_score"}, 32'(out_score), 32'd0);
        check({tag, "_out_err"}, 32'(out_err), 32'd0);
`ifdef ARGMAX_RUNNER_UP_EN
        check({tag, "_out_class2"}, 32'(out_class2), 32'd0);
        check({tag, "_out_margin"}, 32'(out_margin), 32'd0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie at 300 resolves to the lower index.
        frm = '{100, -5, 300, 300, 7, 0, -32768, 299, 1, 2};
        send_frame(1'b1);

        frm = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        send_frame(1'b1);

        frm = '{50, 400, 380, 10, 20, -3, 0, 379, 5, 1};
        send_frame(1'b1);

        // Back-pressure: result held while a new frame is offered.
        out_ready = 1'b0;
        frm = '{3, 8, -1, 8, 2, 9, 0, 4, 7, 6};
        send_frame(1'b1);
        in_valid = 1'b1;
        in_data  = 16'sd123;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_class", 32'(out_class), 32'(last_e.cls));
            check("hold_out_score", 32'(out_score), 32'(last_e.score));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("after_hold_ready", 32'(in_ready), 32'd1);
        check("after_hold_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        frm = '{1, 9, 3, 2};
        send_frame(1'b1);

        frm = '{-7};
        send_frame(1'b1);

        frm = '{5, 4, 3, 2, 1, 11, 0, -1, -2, -3};
        send_frame(1'b0);

        // Reset mid-frame after six beats.
        frm = '{10, 20, 30, 40, 50, 60};
        send_frame(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        frm = '{-100, 5, 17, 0, -9, 30, 12, 29, 31, 30};
        send_frame(1'b1);

        for (int k = 0; k < 4; k++) begin
            frm.delete();
            for (int i = 0; i < NUM; i++) frm.push_back((int'($urandom_range(0, 6)) - 3) * 100);
            send_frame(1'b1);
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
